// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared constants, FSM state and bit-reverse helper for the FFT frame arbiter
package fft_ctrl_pkg;

    localparam int FFT_N_DEFAULT = 128;
    localparam int SAMPLE_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } arb_state_t;

    // Reverses the low 'width' bits of value; higher result bits are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                result[i] = value[width - 1 - i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// rtl/fft_tag_fifo.sv - DEPTH x 1-bit FIFO holding the source requester of each frame in flight
module fft_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_arb.sv
// rtl/fft_frame_arb.sv - two-requester frame arbiter feeding an FFT core and tagging its output frames
module fft_frame_arb
    import fft_ctrl_pkg::*;
#(
    parameter int  N         = FFT_N_DEFAULT,
    parameter int  TAG_DEPTH = 4,
    localparam int NN        = $clog2(N)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            s_valid,
    output logic [1:0]            s_ready,
    input  logic [2*SAMPLE_W-1:0] s0_data,
    input  logic [2*SAMPLE_W-1:0] s1_data,
    output logic                  fft_idata_en,
    output logic [SAMPLE_W-1:0]   fft_idata_r,
    output logic [SAMPLE_W-1:0]   fft_idata_i,
    input  logic                  fft_odata_en,
    output logic                  m_src,
    output logic                  m_sof,
    output logic                  m_eof,
    output logic [NN-1:0]         m_idx,
    output logic                  err_underrun,
    output logic                  err_orphan
);

    arb_state_t            state;
    logic [NN-1:0]         icnt;
    logic [NN-1:0]         ocnt;
    logic                  sel;
    logic                  rr_next;
    logic                  src_hold;
    logic                  boundary;
    logic                  grant;
    logic                  grant_sel;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_head;
    logic                  tag_pop;
    logic [2*SAMPLE_W-1:0] feed_data;

    // Frames are only handed out whole: a new grant is considered when idle or on the last slot.
    assign boundary = (state == IDLE) || (icnt == NN'(N - 1));
    assign grant    = boundary && !tag_full && (s_valid != 2'b00);

    always_comb begin
        grant_sel = rr_next;
        if (!s_valid[rr_next]) begin
            grant_sel = !rr_next;
        end
    end

    assign s_ready   = (state == FEED) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign feed_data = sel ? s1_data : s0_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            icnt         <= '0;
            sel          <= 1'b0;
            rr_next      <= 1'b0;
            fft_idata_en <= 1'b0;
            fft_idata_r  <= '0;
            fft_idata_i  <= '0;
            err_underrun <= 1'b0;
        end else begin
            fft_idata_en <= (state == FEED);
            fft_idata_r  <= '0;
            fft_idata_i  <= '0;
            if (state == FEED) begin
                icnt <= icnt + 1'b1;
                // A starved slot still occupies its position so the FFT frame stays N long.
                if (s_valid[sel]) begin
                    fft_idata_r <= feed_data[2*SAMPLE_W-1:SAMPLE_W];
                    fft_idata_i <= feed_data[SAMPLE_W-1:0];
                end else begin
                    err_underrun <= 1'b1;
                end
            end
            if (grant) begin
                state   <= FEED;
                sel     <= grant_sel;
                rr_next <= !grant_sel;
                icnt    <= '0;
            end else if (boundary) begin
                state <= IDLE;
                icnt  <= '0;
            end
        end
    end

    assign m_sof   = fft_odata_en && (ocnt == '0);
    assign m_eof   = fft_odata_en && (ocnt == NN'(N - 1));
    assign m_idx   = NN'(bit_reverse(32'(ocnt), NN));
    assign tag_pop = m_sof && !tag_empty;
    assign m_src   = m_sof ? (tag_empty ? 1'b0 : tag_head) : src_hold;

    always_ff @(posedge clock) begin
        if (reset) begin
            ocnt       <= '0;
            src_hold   <= 1'b0;
            err_orphan <= 1'b0;
        end else if (fft_odata_en) begin
            ocnt <= ocnt + 1'b1;
            if (m_sof) begin
                src_hold <= tag_empty ? 1'b0 : tag_head;
                if (tag_empty) begin
                    err_orphan <= 1'b1;
                end
            end
        end
    end

    fft_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (grant),
        .push_data(grant_sel),
        .pop      (tag_pop),
        .full     (tag_full),
        .empty    (tag_empty),
        .head     (tag_head)
    );

endmodule
